// File: rtl/iir_mac_stream.sv
// iir_mac_stream: direct-form-I IIR filter of parametrised order. Samples stream from an
// input memory through one shared multiplier-accumulator (2N+1 terms per sample) into an
// output memory. Coefficients are loaded at run time while no run is active.
// Optional macro IIR_SAT_EN: clamp results to the DATA_W range instead of wrapping.
module iir_mac_stream #(
   parameter int ORDER  = 5,
   parameter int DATA_W = 16,
   parameter int COEF_W = 24,
   parameter int FRAC_W = 16,
   parameter int ADDR_W = 20,
   localparam int CSW   = $clog2(2*ORDER+1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] len,
   input  logic              coef_we,
   input  logic [CSW-1:0]    coef_sel,
   input  logic [COEF_W-1:0] coef_data,
   output logic              load,
   output logic [ADDR_W-1:0] RAddr,
   input  logic [DATA_W-1:0] DIn,
   output logic              WEN,
   output logic [ADDR_W-1:0] WAddr,
   output logic [DATA_W-1:0] Yn,
   output logic              busy,
   output logic              Finish
);
   localparam int NCOEF  = 2*ORDER + 1;
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = PROD_W + $clog2(NCOEF);
   localparam logic [CSW-1:0] J_SPLIT = CSW'(ORDER);
   localparam logic [CSW-1:0] J_LAST  = CSW'(2*ORDER);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MAC, S_WRITE, S_DONE} state_t;

   state_t                   state_q, state_d;
   logic [ADDR_W-1:0]        len_q, len_d;
   logic [ADDR_W-1:0]        idx_q, idx_d;
   logic [CSW-1:0]           j_q, j_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [DATA_W-1:0] x_q [0:ORDER];
   logic signed [DATA_W-1:0] x_d [0:ORDER];
   logic signed [DATA_W-1:0] y_q [1:ORDER];
   logic signed [DATA_W-1:0] y_d [1:ORDER];
   logic [NCOEF*COEF_W-1:0]  coef_flat;
   logic                     idle_like;
   logic signed [COEF_W-1:0] coef_cur;
   logic signed [DATA_W-1:0] opnd;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  term;
   logic [DATA_W-1:0]        y_res;

   assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);

   // Coefficient bank: index 0..N holds a0..aN, N+1..2N holds b1..bN; other indices match nothing
   genvar gi;
   generate
      for (gi = 0; gi < NCOEF; gi++) begin : g_coef
         logic [COEF_W-1:0] c_q, c_d;
         // Accept a write to this slot only between runs
         always_comb begin
            c_d = c_q;
            if (coef_we && idle_like && (coef_sel == CSW'(gi)))
               c_d = coef_data;
         end
         // Coefficient register, cleared by reset
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) c_q <= '0;
            else        c_q <= c_d;
         end
         assign coef_flat[gi*COEF_W +: COEF_W] = c_q;
      end
   endgenerate

   // Select coefficient and operand for term j and form the sign-extended product
   always_comb begin
      coef_cur = '0;
      opnd     = DIn;
      for (int k = 0; k < NCOEF; k++)
         if (j_q == CSW'(k)) coef_cur = coef_flat[k*COEF_W +: COEF_W];
      for (int k = 1; k <= ORDER; k++) begin
         if (j_q == CSW'(k))         opnd = x_q[k];
         if (j_q == CSW'(ORDER + k)) opnd = y_q[k];
      end
      prod = coef_cur * opnd;
      term = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
   end

`ifdef IIR_SAT_EN
   logic [ACC_W-FRAC_W-DATA_W:0] res_hi;
   // Floor-scale the accumulator and clamp to the signed sample range
   always_comb begin
      res_hi = acc_q[ACC_W-1:FRAC_W+DATA_W-1];
      if ((res_hi == '0) || (res_hi == '1))
         y_res = acc_q[FRAC_W +: DATA_W];
      else if (acc_q[ACC_W-1])
         y_res = {1'b1, {(DATA_W-1){1'b0}}};
      else
         y_res = {1'b0, {(DATA_W-1){1'b1}}};
   end
`else
   // Floor-scale the accumulator and keep the low sample bits (wraps on overflow)
   assign y_res = acc_q[FRAC_W +: DATA_W];
`endif

   // Sequencer: next state, sample index, MAC term index, accumulator and histories
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      j_d     = j_q;
      acc_d   = acc_q;
      x_d     = x_q;
      y_d     = y_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               len_d   = len;
               idx_d   = '0;
               j_d     = '0;
               acc_d   = '0;
               x_d     = '{default: '0};
               y_d     = '{default: '0};
               state_d = (len == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            j_d     = '0;
            state_d = S_MAC;
         end
         S_MAC: begin
            if (j_q == '0) begin
               acc_d  = term;
               x_d[0] = DIn;
            end else if (j_q > J_SPLIT) begin
               acc_d = acc_q - term;
            end else begin
               acc_d = acc_q + term;
            end
            if (j_q == J_LAST) state_d = S_WRITE;
            else               j_d     = j_q + 1'b1;
         end
         S_WRITE: begin
            // Feed back the quantised output, not the accumulator
            for (int k = 1; k <= ORDER; k++) x_d[k] = x_q[k-1];
            for (int k = 2; k <= ORDER; k++) y_d[k] = y_q[k-1];
            y_d[1] = y_res;
            if (idx_q == len_q - ADDR_W'(1)) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + ADDR_W'(1);
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Run state registers; reset aborts any run in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         j_q     <= '0;
         acc_q   <= '0;
         x_q     <= '{default: '0};
         y_q     <= '{default: '0};
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         j_q     <= j_d;
         acc_q   <= acc_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   assign load   = (state_q == S_FETCH);
   assign RAddr  = load ? idx_q : '0;
   assign WEN    = (state_q == S_WRITE);
   assign WAddr  = WEN ? idx_q : '0;
   assign Yn     = WEN ? y_res : '0;
   assign busy   = (state_q == S_FETCH) || (state_q == S_MAC) || (state_q == S_WRITE);
   assign Finish = (state_q == S_DONE);
endmodule
